multi_queue_dispatch: RTL and testbench
=======================================

# multi_queue_dispatch

Parametrised dispatch stage for the Tomasulo core: accepts one decoded instruction per cycle from the decode side, tags it from an internal free-tag pool, holds it in a one-entry skid register and hands it to the one of NUM_Q execution queues its class selects. Tags are recycled from the CDB. A branch-mispredict flush squashes the held instruction and returns its tag. Sits between instruction decode and the integer/load-store/mult/div issue queues; generalises the fixed four-queue dispatch with fixed tag FIFO.

## Interface
Parameters:
- NUM_Q, 4, number of execution queues (≥2)
- TAG_W, 6, tag width; pool depth D = 2^TAG_W
- INST_W, 32, instruction word width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction present
- in_inst  in  INST_W  decoded instruction
- in_qsel  in  NUM_Q  target queue, one-hot
- in_ready  out  1  stage accepts this cycle
- q_valid  out  NUM_Q  per-queue instruction valid
- q_ready  in  NUM_Q  per-queue ready
- q_inst  out  INST_W  held instruction (shared by all queues)
- q_tag  out  TAG_W  tag of held instruction
- cdb_valid  in  1  CDB broadcast, frees cdb_tag
- cdb_tag  in  TAG_W  tag being freed
- flush  in  1  squash held instruction
- tag_count  out  TAG_W+1  free tags in pool
- tag_overflow  out  1  sticky: push into full pool

## Operation
- Pool: circular buffer of D tags, rd_ptr/wr_ptr TAG_W bits (wrap mod D), count TAG_W+1 bits. Reset contents entry i = i, both pointers 0, count = D.
- Holding register: hold_valid, hold_inst, hold_sel (NUM_Q), hold_tag, hold_nop.
- in_qsel decode: multi-hot → lowest set index wins; all-zero → NOP: accepted, no tag popped, never presented, cleared next cycle.
- fire = hold_valid & !hold_nop & q_ready[sel] & !flush.
- in_ready = !flush & (count ≠ 0) & (!hold_valid | fire | hold_nop). count is the registered value; no same-cycle bypass of a CDB push into an empty pool.
- accept = in_valid & in_ready: load holding register; pop pool (tag = entry[rd_ptr], rd_ptr+1) unless NOP.
- q_valid[i] = hold_valid & !hold_nop & hold_sel[i] & !flush. q_inst/q_tag driven from holding register regardless of valid.
- fire without accept clears hold_valid.
- flush: hold_valid cleared; if a non-NOP instruction was held its hold_tag is pushed back. No new accept during flush.
- Pushes per cycle: up to two (flush-return, then CDB). Written at wr_ptr and wr_ptr+1; wr_ptr advances by number of pushes. count_next = count − pop + pushes.
- Push with count already = D (after that cycle's other pushes): that push dropped, tag_overflow set until reset.
- No duplicate-tag check on CDB.

## Timing
- Reset (async assert): hold_valid 0, q_valid 0, q_inst 0, q_tag 0, tag_count D, tag_overflow 0; in_ready = 1 once rst deasserted.
- Latency: accept in cycle N → q_valid high in N+1. Back-to-back fire/accept sustains 1 instruction/cycle.
- Stall: q_ready low holds q_valid, q_inst, q_tag stable; in_ready low.
- CDB-freed tag visible in tag_count next cycle; pop-able from cycle after.
- Flush coinciding with q_ready: no delivery, tag returned. Flush with empty holding register: no effect.
- rst asserted mid-operation: all state and pool restored to reset values immediately.

## Test plan
- Reset, TAG_W=6: tag_count=64, in_ready=1; send 3 instructions to queue 2 with q_ready=all 1 → q_tag 0,1,2 on consecutive cycles, q_valid=4'b0100, tag_count=61.
- Exhaust pool (64 accepts, no CDB) → in_ready=0, tag_count=0; cdb_valid tag 17 → next cycle in_ready=1, next accept gets tag 17 after wrap.
- q_ready[1]=0 for 5 cycles with held instruction for queue 1 → q_inst/q_tag stable, in_ready=0; release → delivered once, next instruction the following cycle.
- Flush while holding tag 5 plus same-cycle cdb_tag 9 → q_valid=0, tag_count +2, pool order ..., 5, 9.
- Full pool, cdb_valid tag 3 → tag_overflow=1, tag_count stays 64; in_qsel=0 → accepted, no q_valid, count unchanged.
- in_qsel=4'b1010 → delivered to queue 1 only; rst pulsed with holding register full → q_valid=0, tag_count=64 asynchronously.

Source files
------------

// File: rtl/multi_queue_dispatch_if.sv
// rtl/multi_queue_dispatch_if.sv - decode, execution-queue and CDB signals of the dispatch stage
interface multi_queue_dispatch_if #(
    parameter int NUM_Q  = 4,
    parameter int TAG_W  = 6,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic [INST_W-1:0] in_inst;
    logic [NUM_Q-1:0]  in_qsel;
    logic              in_ready;
    logic [NUM_Q-1:0]  q_valid;
    logic [NUM_Q-1:0]  q_ready;
    logic [INST_W-1:0] q_inst;
    logic [TAG_W-1:0]  q_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;

    modport master (
        output in_valid, in_inst, in_qsel, q_ready, cdb_valid, cdb_tag,
        input  in_ready, q_valid, q_inst, q_tag
    );

    modport slave (
        input  in_valid, in_inst, in_qsel, q_ready, cdb_valid, cdb_tag,
        output in_ready, q_valid, q_inst, q_tag
    );
endinterface

// File: rtl/multi_queue_dispatch.sv
// rtl/multi_queue_dispatch.sv - tagging dispatch stage with free-tag pool and one-entry hold register
module multi_queue_dispatch #(
    parameter int NUM_Q  = 4,
    parameter int TAG_W  = 6,
    parameter int INST_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_queue_dispatch_if.slave bus,
    input  logic                  flush,
    output logic [TAG_W:0]        tag_count,
    output logic                  tag_overflow
);
    localparam int             D    = 1 << TAG_W;
    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(D);

    logic [TAG_W-1:0]  pool [D];
    logic [TAG_W-1:0]  rd_ptr;
    logic [TAG_W-1:0]  wr_ptr;
    logic [TAG_W:0]    count;

    logic              hold_valid;
    logic              hold_nop;
    logic [NUM_Q-1:0]  hold_sel;
    logic [INST_W-1:0] hold_inst;
    logic [TAG_W-1:0]  hold_tag;

    logic              fire;
    logic              in_ready;
    logic              accept;
    logic              in_nop;
    logic              pop;
    logic [NUM_Q-1:0]  in_sel;
    logic              push_ret;
    logic              ret_ok;
    logic              cdb_ok;
    logic [TAG_W:0]    cnt_after_ret;
    logic [TAG_W-1:0]  cdb_addr;

    // Handshake, selection decode and push arbitration (flush return has priority over CDB)
    always_comb begin
        fire          = hold_valid & ~hold_nop & (|(hold_sel & bus.q_ready)) & ~flush;
        in_ready      = ~flush & (count != '0) & (~hold_valid | fire | hold_nop);
        accept        = bus.in_valid & in_ready;
        in_nop        = ~(|bus.in_qsel);
        pop           = accept & ~in_nop;
        // isolate the lowest set bit so multi-hot selects collapse to one queue
        in_sel        = bus.in_qsel & (~bus.in_qsel + NUM_Q'(1));
        push_ret      = flush & hold_valid & ~hold_nop;
        ret_ok        = push_ret & (count != FULL);
        cnt_after_ret = count + (TAG_W+1)'(ret_ok);
        cdb_ok        = bus.cdb_valid & (cnt_after_ret != FULL);
        cdb_addr      = wr_ptr + TAG_W'(ret_ok);
    end

    assign bus.in_ready = in_ready;
    assign bus.q_valid  = {NUM_Q{hold_valid & ~hold_nop & ~flush}} & hold_sel;
    assign bus.q_inst   = hold_inst;
    assign bus.q_tag    = hold_tag;
    assign tag_count    = count;

    // Tag pool storage: identity contents at reset, returned tags appended at wr_ptr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < D; i++) pool[i] <= TAG_W'(i);
        end else begin
            if (ret_ok) pool[wr_ptr]   <= hold_tag;
            if (cdb_ok) pool[cdb_addr] <= bus.cdb_tag;
        end
    end

    // Pool pointers, occupancy and sticky overflow for pushes into a full pool
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= FULL;
            tag_overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + TAG_W'(pop);
            wr_ptr <= wr_ptr + TAG_W'(ret_ok) + TAG_W'(cdb_ok);
            count  <= count - (TAG_W+1)'(pop) + (TAG_W+1)'(ret_ok) + (TAG_W+1)'(cdb_ok);
            if ((push_ret & ~ret_ok) | (bus.cdb_valid & ~cdb_ok)) tag_overflow <= 1'b1;
        end
    end

    // Holding register: flush squashes, accept loads, delivery or a held NOP empties it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_nop   <= 1'b0;
            hold_sel   <= '0;
            hold_inst  <= '0;
            hold_tag   <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_nop   <= in_nop;
            hold_sel   <= in_sel;
            hold_inst  <= bus.in_inst;
            if (!in_nop) hold_tag <= pool[rd_ptr];
        end else if (fire | hold_nop) begin
            hold_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_queue_dispatch.sv
// tb/tb_multi_queue_dispatch.sv - scoreboard bench for multi_queue_dispatch
module tb_multi_queue_dispatch;
    typedef struct {
        logic [3:0]  sel;
        logic [5:0]  tag;
        logic [31:0] inst;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [6:0] tag_count;
    logic       tag_overflow;

    int n_chk;
    int n_err;

    exp_t       exp_q[$];
    logic [5:0] mpool[$];
    bit         movf;
    int         c0;

    multi_queue_dispatch_if #(.NUM_Q(4), .TAG_W(6), .INST_W(32)) bus ();

    multi_queue_dispatch #(.NUM_Q(4), .TAG_W(6), .INST_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush        (flush),
        .tag_count    (tag_count),
        .tag_overflow (tag_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mpool.delete();
        for (int i = 0; i < 64; i++) mpool.push_back(6'(i));
        movf = 1'b0;
    endtask

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
        return 4'd0;
    endfunction

    task automatic expect_ready(input logic v);
        #1;
        check("in_ready", bus.in_ready, v);
    endtask

    // One clock: compare outputs against the scoreboard, then advance the model
    task automatic tick();
        exp_t       e;
        logic [3:0] exp_qv;
        @(negedge clk);
        exp_qv = (exp_q.size() != 0 && !flush) ? exp_q[0].sel : 4'd0;
        check("q_valid", bus.q_valid, exp_qv);
        if (exp_q.size() != 0) begin
            check("q_tag", bus.q_tag, exp_q[0].tag);
            check("q_inst", bus.q_inst, exp_q[0].inst);
        end
        check("tag_count", tag_count, mpool.size());
        check("tag_overflow", tag_overflow, movf);
        if ((exp_qv & bus.q_ready) != 0) void'(exp_q.pop_front());
        if (flush && exp_q.size() != 0) begin
            e = exp_q.pop_back();
            if (mpool.size() < 64) mpool.push_back(e.tag);
            else movf = 1'b1;
        end
        if (bus.in_valid && bus.in_ready && bus.in_qsel != 0) begin
            if (mpool.size() == 0) begin
                check("pop_empty", 1, 0);
            end else begin
                e.sel  = lowest(bus.in_qsel);
                e.tag  = mpool.pop_front();
                e.inst = bus.in_inst;
                exp_q.push_back(e);
            end
        end
        if (bus.cdb_valid) begin
            if (mpool.size() < 64) mpool.push_back(bus.cdb_tag);
            else movf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_qsel = '0;
        bus.q_ready = 4'hF;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        model_reset();
        #12;
        check("rst_q_valid", bus.q_valid, 0);
        check("rst_q_inst", bus.q_inst, 0);
        check("rst_q_tag", bus.q_tag, 0);
        check("rst_tag_count", tag_count, 64);
        check("rst_overflow", tag_overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_ready(1'b1);

        // three back-to-back instructions to queue 2
        bus.in_valid = 1'b1;
        bus.in_qsel = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            bus.in_inst = 32'hA000 + 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("first_q_valid", bus.q_valid, 4'b0100);
        tick();
        check("count61", tag_count, 61);

        // exhaust the pool
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && mpool.size() != 0; i++) begin
            bus.in_inst = $urandom;
            bus.in_qsel = 4'($urandom_range(1, 15));
            tick();
        end
        check("exhaust_done", mpool.size(), 0);
        tick();
        expect_ready(1'b0);
        check("empty_count", tag_count, 0);

        // CDB frees tag 17: no same-cycle bypass, accept on the next cycle
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd17;
        expect_ready(1'b0);
        tick();
        bus.cdb_valid = 1'b0;
        expect_ready(1'b1);
        bus.in_inst = 32'hC0DE0017;
        bus.in_qsel = 4'b0001;
        tick();
        bus.in_valid = 1'b0;
        check("wrap_tag17", bus.q_tag, 17);
        tick();

        // refill the pool
        bus.cdb_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.cdb_tag = 6'(i);
            tick();
        end
        bus.cdb_valid = 1'b0;

        // queue 1 stalls for five cycles
        bus.q_ready = 4'b1101;
        bus.in_valid = 1'b1;
        bus.in_inst = 32'hB001;
        bus.in_qsel = 4'b0010;
        tick();
        bus.in_inst = 32'hB002;
        repeat (5) begin
            expect_ready(1'b0);
            tick();
        end
        bus.q_ready = 4'hF;
        expect_ready(1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();

        // flush with a held instruction plus a same-cycle CDB return
        bus.q_ready = 4'h0;
        bus.in_valid = 1'b1;
        bus.in_inst = 32'hF001;
        bus.in_qsel = 4'b0001;
        tick();
        bus.in_valid = 1'b0;
        c0 = int'(tag_count);
        flush = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd9;
        bus.q_ready = 4'hF;
        expect_ready(1'b0);
        check("flush_q_valid", bus.q_valid, 0);
        tick();
        flush = 1'b0;
        bus.cdb_valid = 1'b0;
        check("flush_plus2", tag_count, 7'(c0 + 2));

        // flush with nothing held
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        // fill the pool, then push into it
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd40;
        tick();
        bus.cdb_tag = 6'd3;
        tick();
        bus.cdb_valid = 1'b0;
        check("ovf_sticky", tag_overflow, 1);
        check("ovf_count", tag_count, 64);
        tick();

        // NOP is accepted but never presented
        bus.in_valid = 1'b1;
        bus.in_qsel = 4'b0000;
        bus.in_inst = 32'hDEAD;
        expect_ready(1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("nop_q_valid", bus.q_valid, 0);
        tick();
        check("nop_count", tag_count, 64);

        // multi-hot select goes to the lowest queue
        bus.in_valid = 1'b1;
        bus.in_qsel = 4'b1010;
        bus.in_inst = 32'h1010;
        tick();
        bus.in_valid = 1'b0;
        check("multihot_q_valid", bus.q_valid, 4'b0010);
        tick();

        // drain the pool to check tag ordering after wrap, flush return and CDB
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && mpool.size() != 0; i++) begin
            bus.in_inst = $urandom;
            bus.in_qsel = 4'($urandom_range(0, 15));
            tick();
        end
        bus.in_valid = 1'b0;
        check("drain_done", mpool.size(), 0);
        tick();

        // asynchronous reset with the holding register full
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd5;
        tick();
        bus.cdb_tag = 6'd6;
        tick();
        bus.cdb_valid = 1'b0;
        bus.q_ready = 4'h0;
        bus.in_valid = 1'b1;
        bus.in_qsel = 4'b0100;
        bus.in_inst = 32'h7777;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_q_valid", bus.q_valid, 0);
        check("arst_count", tag_count, 64);
        check("arst_ovf", tag_overflow, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.q_ready = 4'hF;
        bus.in_valid = 1'b1;
        bus.in_qsel = 4'b0001;
        bus.in_inst = 32'h8888;
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_tag0", bus.q_tag, 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
